spi_tx_master: RTL and testbench

SPI master transmit path: the outbound counterpart of the MISO capture chain. Bytes written from the `m_clk` domain go into an internal FIFO. The block generates `spi_clk` and an active-low `spi_cs`, and serializes each byte MSB-first on `spi_mosi_out` in SPI mode 0 (CPOL=0, CPHA=0). Consecutive queued bytes are sent back-to-back inside one chip-select frame.

---
 rtl/spi_tx_master.sv | 215 +++++++++++++++++++++
 tb/tb_spi_tx_master.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_master.sv
// spi_tx_master
// SPI mode 0 (CPOL=0, CPHA=0) transmit master with an internal byte FIFO.
// Words written from the m_clk domain are queued. Each word is then shifted
// out MSB-first on spi_mosi_out. Words that are already queued when a word
// finishes follow it back-to-back inside the same chip-select frame.
//
// Ports
//   m_clk        in   system clock, rising edge
//   n_reset      in   synchronous active-low reset
//   data_in      in   word to queue
//   data_av      in   write strobe (accepted when full=0)
//   full         out  FIFO holds FIFO_DEPTH words
//   overflow     out  sticky: write attempted while full
//   busy         out  engine is not IDLE
//   spi_clk      out  serial clock, idles low
//   spi_cs       out  chip select, active low
//   spi_mosi_out out  serial data, MSB first
module spi_tx_master #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_W     = 8
) (
  input  logic              m_clk,
  input  logic              n_reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_av,
  output logic              full,
  output logic              overflow,
  output logic              busy,
  output logic              spi_clk,
  output logic              spi_cs,
  output logic              spi_mosi_out
);

  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;
  localparam int DIVW = $clog2(CLK_DIV);
  localparam int BW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     w_count_next;
  logic              r_full;
  logic              r_not_empty;
  logic              r_overflow;

  logic [2:0]        r_state;
  logic [DIVW-1:0]   r_div;
  logic [BW-1:0]     r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_sclk;
  logic              r_cs;
  logic              r_mosi;

  logic              w_push;
  logic              w_pop;
  logic              w_can_pop;
  logic              w_div_done;
  logic              w_last_bit;
  logic [DATA_W-1:0] w_head;

  // A write while full is dropped, even if a pop happens in the same cycle.
  assign w_push     = data_av & ~r_full;
  assign w_can_pop  = r_not_empty & (r_count != '0);
  assign w_head     = r_mem[r_rd_ptr];
  assign w_div_done = (r_div == DIVW'(CLK_DIV - 1));
  assign w_last_bit = (r_bit_cnt == BW'(DATA_W - 1));

  // Pops happen when IDLE opens a frame, or on the last falling edge of a
  // word when another word is waiting.
  always_comb begin
    w_pop = 1'b0;
    if (r_state == S_IDLE && w_can_pop)
      w_pop = 1'b1;
    else if (r_state == S_SHIFT && w_div_done && r_sclk && w_last_bit && w_can_pop)
      w_pop = 1'b1;
  end

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)
      w_count_next = r_count + CW'(1);
    else if (!w_push && w_pop)
      w_count_next = r_count - CW'(1);
  end

  // FIFO storage has no reset. The pointers and the count define the contents.
  always_ff @(posedge m_clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= data_in;
  end

  // full tracks the next count, so a write in the cycle after the FIFO
  // fills is already refused. not_empty lags the count by one cycle, which
  // gives IDLE a one-cycle decision step after a write.
  always_ff @(posedge m_clk) begin
    if (!n_reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_not_empty <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count     <= w_count_next;
      r_full      <= (w_count_next == CW'(FIFO_DEPTH));
      r_not_empty <= (r_count != '0);
      r_overflow  <= r_overflow | (data_av & r_full);
    end
  end

  // Frame engine. r_div paces every phase in steps of CLK_DIV cycles. In
  // SHIFT, r_sclk tells whether the next step is a falling or a rising edge.
  always_ff @(posedge m_clk) begin
    if (!n_reset) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_sclk    <= 1'b0;
      r_cs      <= 1'b1;
      r_mosi    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_div  <= '0;
          r_sclk <= 1'b0;
          r_cs   <= 1'b1;
          if (w_can_pop) begin
            r_shift   <= w_head;
            r_mosi    <= w_head[DATA_W-1];
            r_cs      <= 1'b0;
            r_bit_cnt <= '0;
            r_state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_div_done) begin
            r_div   <= '0;
            r_sclk  <= 1'b1;
            r_state <= S_SHIFT;
          end else begin
            r_div <= r_div + DIVW'(1);
          end
        end
        S_SHIFT: begin
          if (w_div_done) begin
            r_div <= '0;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
            end else begin
              r_sclk <= 1'b0;
              if (w_last_bit) begin
                if (w_can_pop) begin
                  r_shift   <= w_head;
                  r_mosi    <= w_head[DATA_W-1];
                  r_bit_cnt <= '0;
                end else begin
                  r_state <= S_HOLD;
                end
              end else begin
                r_shift   <= {r_shift[DATA_W-2:0], 1'b0};
                r_mosi    <= r_shift[DATA_W-2];
                r_bit_cnt <= r_bit_cnt + BW'(1);
              end
            end
          end else begin
            r_div <= r_div + DIVW'(1);
          end
        end
        S_HOLD: begin
          if (w_div_done) begin
            r_div   <= '0;
            r_cs    <= 1'b1;
            r_mosi  <= 1'b0;
            r_state <= S_GAP;
          end else begin
            r_div <= r_div + DIVW'(1);
          end
        end
        S_GAP: begin
          if (w_div_done) begin
            r_div   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_div <= r_div + DIVW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign full         = r_full;
  assign overflow     = r_overflow;
  assign busy         = (r_state != S_IDLE);
  assign spi_clk      = r_sclk;
  assign spi_cs       = r_cs;
  assign spi_mosi_out = r_mosi;

endmodule

// File: tb/tb_spi_tx_master.sv
// tb_spi_tx_master
// Self-checking bench for spi_tx_master. The main instance uses the default
// parameters (CLK_DIV=4). A second instance uses CLK_DIV=2.
// A negedge monitor rebuilds each chip-select frame of the main instance:
// the cycles CS is low, the MOSI bits seen at spi_clk rising edges, the delay
// from CS rise to busy fall, and the CS-high gap before the frame.
module tb_spi_tx_master;

  logic       m_clk;
  logic       n_reset;
  logic [7:0] data_in;
  logic       data_av;
  logic       full4, ovf4, busy4, sclk4, cs4, mosi4;
  logic [7:0] data_in2;
  logic       data_av2;
  logic       full2, ovf2, busy2, sclk2, cs2, mosi2;

  int checks   = 0;
  int failures = 0;

  spi_tx_master #(.CLK_DIV(4), .FIFO_DEPTH(8), .DATA_W(8)) dut4 (
    .m_clk(m_clk), .n_reset(n_reset), .data_in(data_in), .data_av(data_av),
    .full(full4), .overflow(ovf4), .busy(busy4), .spi_clk(sclk4),
    .spi_cs(cs4), .spi_mosi_out(mosi4)
  );

  spi_tx_master #(.CLK_DIV(2), .FIFO_DEPTH(8), .DATA_W(8)) dut2 (
    .m_clk(m_clk), .n_reset(n_reset), .data_in(data_in2), .data_av(data_av2),
    .full(full2), .overflow(ovf2), .busy(busy2), .spi_clk(sclk2),
    .spi_cs(cs2), .spi_mosi_out(mosi2)
  );

  initial m_clk = 1'b0;
  always #5 m_clk = ~m_clk;

  typedef struct {
    int           low;
    logic [127:0] bits;
    int           n;
    int           lag;
    int           gap;
  } frame_t;

  typedef struct {
    int           nWords;
    logic [23:0]  words;
    int           expLow;
    logic [127:0] expBits;
    int           expN;
  } vec_t;

  frame_t frames[$];

  // Monitor state for the CLK_DIV=4 instance.
  int           cyc        = 0;
  int           lowCnt     = 0;
  int           monN       = 0;
  int           highRun    = 0;
  int           curGap     = 0;
  int           csRiseCyc  = 0;
  int           totalRises = 0;
  logic [127:0] monBits    = '0;
  logic         prevClk    = 1'b0;
  logic         prevCs     = 1'b1;
  logic         prevBusy   = 1'b0;

  // Rebuilds frames from the pins. A frame record is closed when busy falls.
  always @(negedge m_clk) begin
    frame_t f;
    cyc = cyc + 1;
    if (!prevClk && sclk4 === 1'b1)
      totalRises = totalRises + 1;
    if (cs4 === 1'b0) begin
      if (prevCs)
        curGap = highRun;
      lowCnt = lowCnt + 1;
      if (!prevClk && sclk4 === 1'b1) begin
        monBits = {monBits[126:0], mosi4};
        monN    = monN + 1;
      end
      highRun = 0;
    end else begin
      if (!prevCs)
        csRiseCyc = cyc;
      highRun = highRun + 1;
    end
    if (prevBusy && busy4 === 1'b0) begin
      f.low  = lowCnt;
      f.bits = monBits;
      f.n    = monN;
      f.lag  = cyc - csRiseCyc;
      f.gap  = curGap;
      frames.push_back(f);
      lowCnt  = 0;
      monBits = '0;
      monN    = 0;
    end
    prevClk  = (sclk4 === 1'b1);
    prevCs   = (cs4 !== 1'b0);
    prevBusy = (busy4 === 1'b1);
  end

  // Compares one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Writes nWords words to the main instance on consecutive edges.
  task automatic applyStimulus(input logic [23:0] words, input int nWords);
    data_av = 1'b1;
    for (int i = 0; i < nWords; i++) begin
      data_in = words[23-8*i -: 8];
      @(posedge m_clk);
      #1;
    end
    data_av = 1'b0;
  endtask

  // Waits, with a bound, for the monitor to close the next frame.
  task automatic waitFrame(input string name, output frame_t f, output bit ok);
    ok = 1'b0;
    f.low = 0; f.bits = '0; f.n = 0; f.lag = 0; f.gap = 0;
    for (int c = 0; c < 3000; c++) begin
      if (frames.size() > 0) break;
      @(negedge m_clk);
    end
    if (frames.size() > 0) begin
      f  = frames.pop_front();
      ok = 1'b1;
    end else begin
      checks   = checks + 1;
      failures = failures + 1;
      $display("[TB] FAIL %s: no frame seen, expected one within 3000 cycles", name);
    end
  endtask

  vec_t         vecs[4];
  frame_t       fr;
  bit           ok;
  logic         fullAfter[10];
  logic         ovfAfter[10];
  logic [7:0]   nineWords[10];
  int           r0;
  int           r1;
  int           low2;
  int           n2;
  int           rise1;
  int           rise2;
  logic [7:0]   bits2;
  logic         pc2;
  bit           seen2;

  initial begin
    vecs[0] = '{1, 24'hA50000, 68,  128'hA5,     8};
    vecs[1] = '{3, 24'h3CFF01, 196, 128'h3CFF01, 24};
    vecs[2] = '{1, 24'h000000, 68,  128'h0,      8};
    vecs[3] = '{2, 24'h817E00, 132, 128'h817E,   16};

    n_reset  = 1'b0;
    data_in  = 8'h00;
    data_av  = 1'b0;
    data_in2 = 8'h00;
    data_av2 = 1'b0;
    repeat (3) @(posedge m_clk);
    #1;
    checkOutput("reset cs",       128'(cs4),   128'(1));
    checkOutput("reset spi_clk",  128'(sclk4), 128'(0));
    checkOutput("reset mosi",     128'(mosi4), 128'(0));
    checkOutput("reset busy",     128'(busy4), 128'(0));
    checkOutput("reset full",     128'(full4), 128'(0));
    checkOutput("reset overflow", 128'(ovf4),  128'(0));
    n_reset = 1'b1;
    repeat (2) @(posedge m_clk);
    #1;

    // First-write latency: CS falls two edges after the write edge, and the
    // first spi_clk rise comes CLK_DIV edges after that.
    data_in = 8'hC3;
    data_av = 1'b1;
    @(posedge m_clk); #1;
    data_av = 1'b0;
    checkOutput("lat cs after write edge", 128'(cs4), 128'(1));
    @(posedge m_clk); #1;
    checkOutput("lat cs at t+1", 128'(cs4), 128'(1));
    @(posedge m_clk); #1;
    checkOutput("lat cs at t+2",   128'(cs4),   128'(0));
    checkOutput("lat busy at t+2", 128'(busy4), 128'(1));
    checkOutput("lat mosi msb",    128'(mosi4), 128'(1));
    repeat (3) @(posedge m_clk);
    #1;
    checkOutput("lat sclk at T+3", 128'(sclk4), 128'(0));
    @(posedge m_clk); #1;
    checkOutput("lat sclk at T+4", 128'(sclk4), 128'(1));
    waitFrame("lat frame", fr, ok);
    if (ok) begin
      checkOutput("lat cs low cycles", 128'(fr.low), 128'(68));
      checkOutput("lat bits",          fr.bits,      128'hC3);
    end

    // Table-driven frames.
    for (int v = 0; v < 4; v++) begin
      applyStimulus(vecs[v].words, vecs[v].nWords);
      waitFrame($sformatf("vec%0d frame", v), fr, ok);
      if (ok) begin
        checkOutput($sformatf("vec%0d cs low", v), 128'(fr.low), 128'(vecs[v].expLow));
        checkOutput($sformatf("vec%0d bits", v),   fr.bits,      vecs[v].expBits);
        checkOutput($sformatf("vec%0d nbits", v),  128'(fr.n),   128'(vecs[v].expN));
        checkOutput($sformatf("vec%0d busy lag", v), 128'(fr.lag), 128'(4));
      end
    end

    // Ten writes on consecutive edges: nine fit (one pops at cycle 2), the
    // tenth is dropped and sets overflow.
    for (int i = 0; i < 10; i++)
      nineWords[i] = 8'h11 * 8'(i + 1);
    data_av = 1'b1;
    data_in = nineWords[0];
    for (int k = 0; k < 10; k++) begin
      @(posedge m_clk); #1;
      fullAfter[k] = full4;
      ovfAfter[k]  = ovf4;
      if (k < 9)
        data_in = nineWords[k+1];
      else
        data_av = 1'b0;
    end
    checkOutput("fill full after write 8",  128'(fullAfter[7]), 128'(0));
    checkOutput("fill full after write 9",  128'(fullAfter[8]), 128'(1));
    checkOutput("fill full after write 10", 128'(fullAfter[9]), 128'(1));
    checkOutput("fill ovf after write 9",   128'(ovfAfter[8]),  128'(0));
    checkOutput("fill ovf after write 10",  128'(ovfAfter[9]),  128'(1));
    waitFrame("fill frame", fr, ok);
    if (ok) begin
      checkOutput("fill nbits",  128'(fr.n),   128'(72));
      checkOutput("fill cs low", 128'(fr.low), 128'(580));
      checkOutput("fill bits",   fr.bits,      128'h112233445566778899);
    end
    checkOutput("fill full after drain", 128'(full4), 128'(0));
    checkOutput("fill ovf sticky",       128'(ovf4),  128'(1));

    // A write during HOLD opens a second frame instead of extending the first.
    data_in = 8'h80;
    data_av = 1'b1;
    @(posedge m_clk); #1;
    data_av = 1'b0;
    repeat (66) @(posedge m_clk);
    #1;
    checkOutput("hold cs",   128'(cs4),   128'(0));
    checkOutput("hold sclk", 128'(sclk4), 128'(0));
    data_in = 8'h55;
    data_av = 1'b1;
    @(posedge m_clk); #1;
    data_av = 1'b0;
    waitFrame("hold frame 1", fr, ok);
    if (ok) begin
      checkOutput("hold f1 nbits",  128'(fr.n),   128'(8));
      checkOutput("hold f1 bits",   fr.bits,      128'h80);
      checkOutput("hold f1 cs low", 128'(fr.low), 128'(68));
    end
    waitFrame("hold frame 2", fr, ok);
    if (ok) begin
      checkOutput("hold f2 bits",     fr.bits,            128'h55);
      checkOutput("hold f2 nbits",    128'(fr.n),         128'(8));
      checkOutput("hold gap >= 5",    128'(fr.gap >= 5),  128'(1));
    end

    // Reset after the third rising spi_clk of 0xF0 with two words queued.
    r0 = totalRises;
    applyStimulus(24'hF0AABB, 3);
    for (int c = 0; c < 200; c++) begin
      if (totalRises >= r0 + 3) break;
      @(negedge m_clk);
    end
    checkOutput("abort third rise seen", 128'(totalRises - r0), 128'(3));
    n_reset = 1'b0;
    @(posedge m_clk); #1;
    checkOutput("abort cs",       128'(cs4),   128'(1));
    checkOutput("abort sclk",     128'(sclk4), 128'(0));
    checkOutput("abort mosi",     128'(mosi4), 128'(0));
    checkOutput("abort busy",     128'(busy4), 128'(0));
    checkOutput("abort full",     128'(full4), 128'(0));
    checkOutput("abort overflow", 128'(ovf4),  128'(0));
    n_reset = 1'b1;
    r1 = totalRises;
    repeat (150) @(negedge m_clk);
    checkOutput("abort no more clocks", 128'(totalRises - r1), 128'(0));
    checkOutput("abort stays idle cs",  128'(cs4),   128'(1));
    checkOutput("abort stays idle busy", 128'(busy4), 128'(0));
    frames.delete();

    // CLK_DIV=2 instance: 0x96, spi_clk period of 4 cycles, CS low 34 cycles.
    low2  = 0;
    n2    = 0;
    rise1 = -1;
    rise2 = -1;
    bits2 = 8'h00;
    pc2   = 1'b0;
    seen2 = 1'b0;
    @(posedge m_clk); #1;
    data_in2 = 8'h96;
    data_av2 = 1'b1;
    @(posedge m_clk); #1;
    data_av2 = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge m_clk);
      if (cs2 === 1'b0) begin
        seen2 = 1'b1;
        low2  = low2 + 1;
        if (!pc2 && sclk2 === 1'b1) begin
          bits2 = {bits2[6:0], mosi2};
          n2    = n2 + 1;
          if (rise1 < 0)
            rise1 = c;
          else if (rise2 < 0)
            rise2 = c;
        end
      end else if (seen2) begin
        break;
      end
      pc2 = (sclk2 === 1'b1);
    end
    checkOutput("div2 cs low",     128'(low2),          128'(34));
    checkOutput("div2 bits",       128'(bits2),         128'h96);
    checkOutput("div2 nbits",      128'(n2),            128'(8));
    checkOutput("div2 clk period", 128'(rise2 - rise1), 128'(4));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
